// File: rtl/mem_pipe_if.sv
// Request/response bundle for mem_pipe: the requester drives req..be and receives
// ready/rvalid/rdata/err from the memory.
`timescale 1ns/1ps
interface mem_pipe_if #(
    parameter int unsigned WIDTH = 32
) ();
    localparam int unsigned NB = WIDTH / 8;

    logic             req;
    logic             we;
    logic [31:0]      addr;
    logic [WIDTH-1:0] wdata;
    logic [NB-1:0]    be;
    logic             ready;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic             err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_pipe.sv
// Single-port word memory with byte enables, fixed read/write response latency and
// an error response for misaligned or out-of-range byte addresses.
`timescale 1ns/1ps
module mem_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned LATENCY   = 2
) (
    input logic      clk,
    input logic      rst_n,
    mem_pipe_if.slave bus
);
    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned OFF   = $clog2(NB);
    localparam int unsigned Depth = 2 ** ADDR_BITS;
    localparam int unsigned CntW  = 3;
    localparam logic [31:0] AlignMask = 32'(NB - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0]     mem_q [Depth];
    logic [ADDR_BITS-1:0] idx;
    logic                 misaligned;
    logic                 out_of_range;
    logic                 fault;
    logic                 mem_we;

    assign idx          = bus.addr[ADDR_BITS+OFF-1:OFF];
    assign misaligned   = (bus.addr & AlignMask) != '0;
    assign out_of_range = (bus.addr >> (ADDR_BITS + OFF)) != '0;
    assign fault        = misaligned | out_of_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    state_d = StBusy;
                    cnt_d   = CntW'(LATENCY - 1);
                    if (fault) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        err_d   = 1'b0;
                        // Read data is snapshotted here so later writes cannot disturb it.
                        rdata_d = bus.we ? '0 : mem_q[idx];
                        mem_we  = bus.we & rst_n;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array: no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (bus.be[i]) begin
                    mem_q[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.ready  = (state_q == StIdle);
    assign bus.rvalid = (state_q == StResp);
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_mem_pipe.sv
// Randomised and directed checks of mem_pipe against an array-level reference model,
// with extra LATENCY=1 and LATENCY=8 instances exercised under a continuously held req.
`timescale 1ns/1ps
module tb_mem_pipe;
    localparam int unsigned W  = 32;
    localparam int unsigned AB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_pipe_if #(.WIDTH(W)) bus2 ();
    mem_pipe_if #(.WIDTH(W)) bus1 ();
    mem_pipe_if #(.WIDTH(W)) bus8 ();

    mem_pipe #(.WIDTH(W), .ADDR_BITS(AB), .LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    mem_pipe #(.WIDTH(W), .ADDR_BITS(AB), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    mem_pipe #(.WIDTH(W), .ADDR_BITS(AB), .LATENCY(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] ref_mem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference: byte address -> word array, faults on misalignment or high bits set.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] b, output logic [31:0] exp_rdata,
                                output logic exp_err);
        int unsigned word;
        if ((a % 4) != 0 || a >= 32'd1024) begin
            exp_err   = 1'b1;
            exp_rdata = '0;
        end else begin
            word    = a / 4;
            exp_err = 1'b0;
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) ref_mem[word][8*i +: 8] = d[8*i +: 8];
                exp_rdata = '0;
            end else begin
                exp_rdata = ref_mem[word];
            end
        end
    endtask

    // Called at a negedge with dut2 idle; returns at the negedge where it is idle again.
    task automatic do_op(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input bit junk);
        logic [31:0] er;
        logic        ee;
        bus2.req = 1'b1; bus2.we = w; bus2.addr = a; bus2.wdata = d; bus2.be = b;
        chk({tag, "_ready_pre"}, 32'(bus2.ready), 32'd1);
        model_access(w, a, d, b, er, ee);
        @(posedge clk);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk({tag, "_rvalid"}, 32'(bus2.rvalid), 32'(k == 2));
            chk({tag, "_ready"}, 32'(bus2.ready), 32'(k == 3));
            if (k >= 2) begin
                chk({tag, "_rdata"}, bus2.rdata, er);
                chk({tag, "_err"}, 32'(bus2.err), 32'(ee));
            end
            if (junk && k < 2) begin
                bus2.req = 1'b1; bus2.we = 1'($urandom); bus2.addr = $urandom_range(0, 1023);
                bus2.wdata = $urandom; bus2.be = 4'($urandom);
            end else begin
                bus2.req = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        int          m;
        bus1.req = 0; bus1.we = 0; bus1.addr = 0; bus1.wdata = 0; bus1.be = 0;
        bus8.req = 0; bus8.we = 0; bus8.addr = 0; bus8.wdata = 0; bus8.be = 0;
        // Reset with a pending write request held high.
        bus2.req = 1; bus2.we = 1; bus2.addr = 32'h10; bus2.wdata = 32'hAAAA_AAAA; bus2.be = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus2.ready), 32'd1);
        chk("rst_rvalid", 32'(bus2.rvalid), 32'd0);
        chk("rst_err", 32'(bus2.err), 32'd0);
        chk("rst_rdata", bus2.rdata, 32'd0);
        bus2.req = 0;
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 256; i++) do_op("fill", 1'b1, 32'(i) << 2, $urandom, 4'hF, 1'b0);

        // A write request during reset must not reach the array.
        rst_n = 0;
        bus2.req = 1; bus2.we = 1; bus2.addr = 32'h10; bus2.wdata = 32'h5555_5555; bus2.be = 4'hF;
        repeat (3) @(negedge clk);
        bus2.req = 0;
        rst_n = 1;
        @(negedge clk);
        do_op("rst_nowrite", 1'b0, 32'h10, 0, 4'h0, 1'b0);

        do_op("wr_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        do_op("rd_full", 1'b0, 32'h10, 0, 4'h0, 1'b0);
        do_op("wr_part", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 1'b0);
        do_op("rd_part", 1'b0, 32'h10, 0, 4'h0, 1'b0);
        do_op("wr_be0", 1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0, 1'b0);
        do_op("rd_be0", 1'b0, 32'h14, 0, 4'h0, 1'b0);
        do_op("wr_misal", 1'b1, 32'h12, 32'h0, 4'hF, 1'b0);
        do_op("rd_after_misal", 1'b0, 32'h10, 0, 4'h0, 1'b0);
        do_op("rd_oor", 1'b0, 32'h400, 0, 4'h0, 1'b0);
        do_op("wr_oor_hi", 1'b1, 32'hFFFF_FFF0, 32'h1, 4'hF, 1'b0);
        do_op("rd_last", 1'b0, 32'h3FC, 0, 4'h0, 1'b0);

        // Reset while a read is in flight: response is dropped.
        bus2.req = 1; bus2.we = 0; bus2.addr = 32'h10;
        @(posedge clk);
        #1 bus2.req = 0;
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midrst_ready", 32'(bus2.ready), 32'd1);
        chk("midrst_rvalid", 32'(bus2.rvalid), 32'd0);
        chk("midrst_rdata", bus2.rdata, 32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_rvalid", 32'(bus2.rvalid), 32'd0);
            chk("midrst_idle", 32'(bus2.ready), 32'd1);
        end
        do_op("rd_after_midrst", 1'b0, 32'h10, 0, 4'h0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'($urandom_range(0, 255)) << 2;
            else if (sel == 7) a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 8) a = $urandom | (32'h1 << $urandom_range(10, 31));
            else               a = ($urandom_range(0, 1) != 0) ? 32'h3FC : 32'h400;
            do_op("rand", 1'($urandom), a, $urandom, 4'($urandom), 1'($urandom));
        end

        // Back-to-back misaligned reads with req held: accepts every LATENCY+2 edges.
        bus1.req = 1; bus1.addr = 32'h1;
        bus8.req = 1; bus8.addr = 32'h1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            m = n % 3;
            chk("l1_rvalid", 32'(bus1.rvalid), 32'(m == 1));
            chk("l1_ready", 32'(bus1.ready), 32'(m == 2));
            if (m == 1) chk("l1_err", 32'(bus1.err), 32'd1);
            m = n % 10;
            chk("l8_rvalid", 32'(bus8.rvalid), 32'(m == 8));
            chk("l8_ready", 32'(bus8.ready), 32'(m == 9));
            if (m == 8) chk("l8_rdata", bus8.rdata, 32'd0);
            bus1.we = 1'($urandom);
            bus8.we = 1'($urandom);
        end
        bus1.req = 0;
        bus8.req = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
